// File: rtl/ring_output_arbiter_if.sv
// Request/grant bundle between the router input stages and the ring output
// arbiter. The master side owns the phase, buffer status and requests; the
// slave side (the arbiter) returns the one-hot grant and status.
interface ring_output_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic              polarity;
    logic              buf_free;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  grant;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [N_REQ-1:0]  starved;
    logic [CNT_W-1:0]  grant_count;

    modport master (
        output polarity,
        output buf_free,
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx,
        input  starved,
        input  grant_count
    );

    modport slave (
        input  polarity,
        input  buf_free,
        input  req,
        output grant,
        output grant_valid,
        output grant_idx,
        output starved,
        output grant_count
    );
endinterface

// File: rtl/ring_output_arbiter.sv
// Round-robin arbiter for one ring output-channel slot. Separate pointers for
// the even and odd buffer phases keep each phase fair on its own; per-requester
// wait counters escalate a requester once it has waited STARVE_LIMIT cycles.
// The grant is combinational so the ack reaches the requester in-cycle.
module ring_output_arbiter #(
    parameter int N_REQ        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ring_output_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counter increment that sticks at lim once reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        if (v >= lim) begin
            return lim;
        end
        return v + CNT_W'(1);
    endfunction

    // Pointer advance past the winner, wrapping the last requester to 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= N_REQ - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    logic [IDX_W-1:0] ptr_even_q, ptr_even_d;
    logic [IDX_W-1:0] ptr_odd_q,  ptr_odd_d;
    logic [CNT_W-1:0] wait_q [N_REQ];
    logic [CNT_W-1:0] wait_d [N_REQ];
    logic [CNT_W-1:0] count_q, count_d;

    logic [N_REQ-1:0] starved_raw;
    logic [N_REQ-1:0] escalate;
    logic [N_REQ-1:0] grant_w;
    logic [IDX_W-1:0] grant_idx_w;
    logic [IDX_W-1:0] active_ptr;
    logic             found;

    // Starvation flags come straight from the registered wait counters.
    always_comb begin
        starved_raw = '0;
        for (int i = 0; i < N_REQ; i++) begin
            starved_raw[i] = (wait_q[i] == LIMIT);
        end
        escalate = starved_raw & bus.req;
    end

    // Winner selection: lowest escalated requester first, else round robin
    // from the pointer of the phase being written this cycle.
    always_comb begin
        grant_w     = '0;
        grant_idx_w = '0;
        found       = 1'b0;
        active_ptr  = bus.polarity ? ptr_odd_q : ptr_even_q;
        if (!reset && bus.buf_free) begin
            if (|escalate) begin
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (escalate[IDX_W'(i)]) begin
                        grant_idx_w = IDX_W'(i);
                        found       = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (!found && bus.req[IDX_W'((int'(active_ptr) + k) % N_REQ)]) begin
                        grant_idx_w = IDX_W'((int'(active_ptr) + k) % N_REQ);
                        found       = 1'b1;
                    end
                end
            end
        end
        if (found) begin
            grant_w = N_REQ'(1) << grant_idx_w;
        end
    end

    assign bus.grant       = grant_w;
    assign bus.grant_valid = found;
    assign bus.grant_idx   = grant_idx_w;
    assign bus.starved     = reset ? '0 : starved_raw;
    assign bus.grant_count = count_q;

    // Next-state: only the active phase pointer moves on a grant; wait
    // counters clear on grant or withdrawal and otherwise keep counting,
    // including while the buffer is full.
    always_comb begin
        ptr_even_d = ptr_even_q;
        ptr_odd_d  = ptr_odd_q;
        count_d    = count_q;
        for (int i = 0; i < N_REQ; i++) begin
            wait_d[i] = wait_q[i];
        end
        if (found) begin
            if (bus.polarity) begin
                ptr_odd_d = next_ptr(grant_idx_w);
            end else begin
                ptr_even_d = next_ptr(grant_idx_w);
            end
            count_d = sat_inc(count_q, CNT_MAX);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_w[i] || !bus.req[i]) begin
                wait_d[i] = '0;
            end else begin
                wait_d[i] = sat_inc(wait_q[i], LIMIT);
            end
        end
    end

    // State registers with synchronous reset; reset suppresses any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_even_q <= '0;
            ptr_odd_q  <= '0;
            count_q    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            ptr_even_q <= ptr_even_d;
            ptr_odd_q  <= ptr_odd_d;
            count_q    <= count_d;
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end
endmodule

// File: tb/tb_ring_output_arbiter.sv
// Scoreboard bench for ring_output_arbiter: a stimulus process drives each
// cycle and queues the response predicted by a behavioural model; a monitor
// on the falling edge pops and compares.
module tb_ring_output_arbiter;
    localparam int N     = 4;
    localparam int LIMIT = 8;
    localparam int CMAX  = 255;

    typedef struct {
        logic [3:0] grant;
        logic       vld;
        logic [1:0] idx;
        logic [3:0] starved;
        logic [7:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    exp_t exp_q[$];

    // reference model state
    int ptr[2];
    int wcnt[N];
    int gcount;
    int last_g;

    ring_output_arbiter_if #(.N_REQ(N), .CNT_W(8)) bus();

    ring_output_arbiter #(
        .N_REQ(N),
        .STARVE_LIMIT(LIMIT),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        ptr[0] = 0;
        ptr[1] = 0;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        gcount = 0;
    endtask

    // Apply one cycle of stimulus, predict the response, advance the model.
    task automatic drive(input logic rst, input logic [3:0] r, input logic bf, input logic pol);
        exp_t e;
        int   g;
        int   p;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.req      = r;
        bus.buf_free = bf;
        bus.polarity = pol;
        p = pol ? 1 : 0;
        g = -1;
        if (!rst && bf && r != 4'b0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i] && wcnt[i] == LIMIT) g = i;
            end
            if (g < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && r[(ptr[p] + k) % N]) g = (ptr[p] + k) % N;
                end
            end
        end
        e.vld     = (g >= 0);
        e.grant   = (g >= 0) ? 4'(1 << g) : 4'b0;
        e.idx     = (g >= 0) ? 2'(g) : 2'b0;
        e.starved = 4'b0;
        if (!rst) begin
            for (int i = 0; i < N; i++) e.starved[i] = (wcnt[i] == LIMIT);
        end
        e.count = 8'(gcount);
        exp_q.push_back(e);
        last_g = g;
        if (rst) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                ptr[p] = (g + 1) % N;
                if (gcount < CMAX) gcount++;
            end
            for (int i = 0; i < N; i++) begin
                if (g == i || !r[i]) wcnt[i] = 0;
                else if (wcnt[i] < LIMIT) wcnt[i]++;
            end
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant",       32'(bus.grant),       32'(e.grant));
            chk("grant_valid", 32'(bus.grant_valid), 32'(e.vld));
            chk("grant_idx",   32'(bus.grant_idx),   32'(e.idx));
            chk("starved",     32'(bus.starved),     32'(e.starved));
            chk("grant_count", 32'(bus.grant_count), 32'(e.count));
            chk("onehot",      32'($countones(bus.grant) <= 1), 32'(1));
        end
    end

    initial begin
        logic [3:0] held;
        logic [3:0] r;
        reset        = 1'b1;
        bus.req      = '0;
        bus.buf_free = 1'b0;
        bus.polarity = 1'b0;
        model_reset();
        last_g = -1;
        repeat (2) @(posedge clk);

        // reset state with requests pending
        drive(1'b1, 4'b1111, 1'b1, 1'b0);

        // full request set on the even phase: 0,1,2,3
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b1111, 1'b1, 1'b0);
            #1 chk("rr_seq_idx", 32'(bus.grant_idx), 32'(i));
        end
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        #1 chk("count_after_4", 32'(bus.grant_count), 32'd4);

        // alternating phases, independent pointers
        for (int i = 0; i < 8; i++) drive(1'b0, 4'b0101, 1'b1, 1'(i % 2));

        // backpressure starvation then escalation
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 4'b1000, 1'b0, 1'b0);
        drive(1'b0, 4'b1001, 1'b1, 1'b0);
        #1 chk("escalated_idx", 32'(bus.grant_idx), 32'd3);
        chk("escalated_starved", 32'(bus.starved[3]), 32'd1);
        drive(1'b0, 4'b0001, 1'b1, 1'b0);
        #1 chk("starved_cleared", 32'(bus.starved[3]), 32'd0);

        // buf_free toggling
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 4'b0110, 1'(i % 2 == 0), 1'b0);

        // reset mid-stream after three grants
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b1111, 1'b1, 1'b0);
        drive(1'b1, 4'b1111, 1'b1, 1'b0);
        drive(1'b0, 4'b1111, 1'b1, 1'b0);
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        #1 chk("count_after_reset", 32'(bus.grant_count), 32'd1);

        // grant counter saturation
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 4'b0001, 1'b1, 1'($urandom_range(0, 1)));
        #1 chk("count_sat", 32'(bus.grant_count), 32'd255);

        // random traffic with occasional reset and withdrawal
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 99) == 0), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
        end

        // random traffic with held requests and heavy backpressure
        held = 4'b0;
        for (int i = 0; i < 1500; i++) begin
            r = held | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            drive(1'($urandom_range(0, 199) == 0), r, 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)));
            held = r;
            if (last_g >= 0) held[last_g] = 1'b0;
            if (reset) held = 4'b0;
        end

        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ring_output_arbiter.md
Name: ring_output_arbiter

Overview:
- N-way round-robin arbiter for one ring output-channel slot.
- Shares the even/odd output buffer among local and transit requesters.
- Keeps a separate round-robin pointer per polarity (even/odd phase) and a starvation-escalation counter per requester.
- Sits between the router input stages and the output-channel buffer; drives the per-requester ack path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- STARVE_LIMIT, 8, cycles a requester may wait before it is escalated (1..255).
- CNT_W, 8, width of the wait counters and of the grant statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- polarity  in  1  current ring phase; 1 = odd buffer written this cycle, 0 = even
- buf_free  in  1  target buffer for the current polarity is empty and may accept a flit this cycle
- req  in  N_REQ  per-requester request, level, held until granted
- grant  out  N_REQ  one-hot grant, combinational, valid in the same cycle
- grant_valid  out  1  OR of grant
- grant_idx  out  clog2(N_REQ)  index of the granted requester; 0 when none
- starved  out  N_REQ  requester wait counter has reached STARVE_LIMIT
- grant_count  out  CNT_W  saturating total of grants issued since reset

Behaviour:
- Reset (sync, 1 cycle):
  - ptr_even = ptr_odd = 0.
  - All wait counters = 0; grant_count = 0.
  - grant, grant_valid, grant_idx and starved are all 0 during the reset cycle, regardless of req.
- Grant logic is combinational; ack reaches the requester in the same cycle, and the requester's flit is written at the next clock edge.
- No grant is issued if buf_free = 0 or req = 0.
- Exactly zero or one grant bit is set at any time.
- Active pointer is ptr_odd when polarity = 1, otherwise ptr_even.
- Priority, evaluated each cycle with buf_free = 1:
  - If any starved[i] & req[i]: grant the lowest such index (escalation overrides round robin).
  - Else: grant the first req[i] scanning from the active pointer upward, wrapping modulo N_REQ.
- Pointer update at posedge, only when grant_valid = 1:
  - Only the active pointer updates: it becomes (grant_idx + 1) mod N_REQ, wrapping N_REQ-1 to 0.
  - The inactive pointer holds.
- Wait counter i at posedge:
  - Cleared to 0 if grant[i] = 1 or req[i] = 0.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - Increments while buf_free = 0 too: backpressure time counts as waiting.
- starved[i] = (wait_cnt[i] == STARVE_LIMIT), registered-state derived.
  - A requester that drops req clears starved the next cycle.
- grant_count increments on every cycle with grant_valid = 1 and saturates at 2^CNT_W - 1.
- Simultaneous events:
  - Polarity toggling every cycle is legal; each phase's fairness is independent.
  - A req rising in the same cycle it would win is granted immediately; there is no request registration latency.
- Reset while a grant is asserted: the grant is deasserted immediately and no pointer or counter update occurs for that cycle.
- req[i] dropping without a grant is legal (withdrawal). It has no effect other than clearing counter i.

Test Plan:
- Reset, then req = 4'b1111, buf_free = 1, polarity = 0 held for 4 cycles.
  - Required: grant_idx sequence 0, 1, 2, 3; ptr_even returns to 0; grant_count = 4.
- Alternate polarity every cycle with req = 4'b0101 and buf_free = 1.
  - Required: even phases grant 0, 2, 0, ... and odd phases grant 0, 2, 0, ...
  - Each pointer advances only on its own phase.
- req = 4'b1000 with buf_free = 0 for 8 cycles (STARVE_LIMIT = 8).
  - Required: starved[3] = 1 after the 8th edge.
  - Then raise req = 4'b1001 and buf_free = 1: grant_idx = 3 despite ptr = 0. starved[3] clears the next cycle.
- req = 4'b0110 with buf_free toggling 1, 0, 1, 0.
  - Required: grants issued only on buf_free = 1 cycles, idx 1 then 2.
  - Pointer unchanged during buf_free = 0 cycles.
- Assert reset mid-stream with req = 4'b1111, buf_free = 1, after 3 grants.
  - Required: grant = 0 during the reset cycle; the next grant is idx 0; grant_count = 1 after it.
- Hold req[0] for 300 grants with CNT_W = 8.
  - Required: grant_count saturates at 255; one-hot property holds on every cycle.
